// File: rtl/conv_cfg_sequencer.sv
// Command sequencer feeding MEM_Comp: buffers config words, then issues LOAD or RUN transactions.
// Optional command validation (sticky err) is enabled by defining CFG_SEQ_CMD_CHECK_EN.
module conv_cfg_sequencer #(
  parameter int WORD_W = 43,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 5,
  parameter int LAT_W  = 16,
  parameter int GCTL_W = 126
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] cfg_wdata,
  input  logic              cfg_wvalid,
  output logic              cfg_wready,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_stride,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [LAT_W-1:0]  cmd_start_lat,
  input  logic [LAT_W-1:0]  cmd_end_lat,
  input  logic [GCTL_W-1:0] cmd_gctl,
  input  logic              cmd_mux_sel,
  output logic [WORD_W-1:0] dataIn,
  output logic [ADDR_W-1:0] startAddr,
  output logic [3:0]        strideInterval,
  output logic [LAT_W-1:0]  startLatency,
  output logic [LAT_W-1:0]  endLatency,
  output logic              valid,
  output logic              writeEn,
  output logic [GCTL_W-1:0] gControlIn,
  output logic              mux_sel,
  output logic              done,
  output logic              busy,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMP_W = (CNT_W > LEN_W) ? CNT_W : LEN_W;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FILL     = 3'd1;
  localparam logic [2:0] SETUP    = 3'd2;
  localparam logic [2:0] STREAM   = 3'd3;
  localparam logic [2:0] RUN_WAIT = 3'd4;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtrReg;
  logic [PTR_W-1:0]  rdPtrReg;
  logic [CNT_W-1:0]  countReg;

  logic [2:0]        stateReg;
  logic              cmdReadyReg;
  logic              opReg;
  logic [ADDR_W-1:0] addrReg;
  logic [3:0]        strideReg;
  logic [LEN_W-1:0]  lenReg;
  logic [LEN_W-1:0]  remainReg;
  logic [LAT_W-1:0]  startLatReg;
  logic [LAT_W-1:0]  endLatReg;
  logic [LAT_W-1:0]  latCntReg;

  logic fifoFull;
  logic pushEn;
  logic popEn;
  logic accept;
  logic cmdBad;
  logic haveCmdLen;
  logic haveLatchedLen;

  assign fifoFull   = (countReg == FULL_COUNT);
  assign cfg_wready = !fifoFull;
  assign pushEn     = cfg_wvalid && !fifoFull;
  assign cmd_ready  = cmdReadyReg;
  assign busy       = (stateReg != IDLE);
  assign accept     = cmd_valid && cmdReadyReg;

  assign haveCmdLen     = (CMP_W'(countReg) >= CMP_W'(cmd_len));
  assign haveLatchedLen = (CMP_W'(countReg) >= CMP_W'(lenReg));

  // Pops coincide exactly with the FSM branches that load a word onto dataIn.
  assign popEn = ((stateReg == SETUP) && !opReg && (lenReg != '0)) ||
                 ((stateReg == STREAM) && (remainReg != '0));

`ifdef CFG_SEQ_CMD_CHECK_EN
  localparam logic [LEN_W:0]        DEPTH_LIM = (LEN_W+1)'(DEPTH);
  localparam logic [ADDR_W+LEN_W:0] ADDR_LIM  = (ADDR_W+LEN_W+1)'(1) << ADDR_W;
  logic [ADDR_W+LEN_W:0] cmdSpan;
  logic                  errReg;

  assign cmdSpan = (ADDR_W+LEN_W+1)'(cmd_addr) + (ADDR_W+LEN_W+1)'(cmd_len);
  // Length and address-span limits only matter for LOAD; RUN ignores cmd_len.
  assign cmdBad  = (!cmd_op && ((cmd_len == '0) || ({1'b0, cmd_len} > DEPTH_LIM) ||
                                (cmdSpan > ADDR_LIM))) ||
                   (cmd_end_lat < cmd_start_lat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      errReg <= 1'b0;
    end else if (accept && cmdBad) begin
      errReg <= 1'b1;
    end
  end
  assign err = errReg;
`else
  assign cmdBad = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (pushEn) begin
      mem[wrPtrReg] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (pushEn) wrPtrReg <= wrPtrReg + 1'b1;
      if (popEn)  rdPtrReg <= rdPtrReg + 1'b1;
      if (pushEn && !popEn)      countReg <= countReg + 1'b1;
      else if (!pushEn && popEn) countReg <= countReg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg       <= IDLE;
      cmdReadyReg    <= 1'b0;
      opReg          <= 1'b0;
      addrReg        <= '0;
      strideReg      <= '0;
      lenReg         <= '0;
      remainReg      <= '0;
      startLatReg    <= '0;
      endLatReg      <= '0;
      latCntReg      <= '0;
      dataIn         <= '0;
      startAddr      <= '0;
      strideInterval <= '0;
      startLatency   <= '0;
      endLatency     <= '0;
      valid          <= 1'b0;
      writeEn        <= 1'b0;
      gControlIn     <= '0;
      mux_sel        <= 1'b0;
      done           <= 1'b0;
    end else begin
      valid       <= 1'b0;
      done        <= 1'b0;
      cmdReadyReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (!accept) begin
            // Also covers the completion cycle, keeping cmd_ready low while done is high.
            cmdReadyReg <= 1'b1;
          end else begin
            opReg       <= cmd_op;
            addrReg     <= cmd_addr;
            strideReg   <= cmd_stride;
            lenReg      <= cmd_len;
            startLatReg <= cmd_start_lat;
            endLatReg   <= cmd_end_lat;
            if (cmdBad) begin
              cmdReadyReg <= 1'b1;
            end else if (cmd_op || haveCmdLen) begin
              startAddr      <= cmd_addr;
              strideInterval <= cmd_stride;
              startLatency   <= cmd_start_lat;
              endLatency     <= cmd_end_lat;
              valid          <= 1'b1;
              writeEn        <= !cmd_op;
              if (cmd_op) begin
                gControlIn <= cmd_gctl;
                mux_sel    <= cmd_mux_sel;
              end
              stateReg <= SETUP;
            end else begin
              stateReg <= FILL;
            end
          end
        end
        FILL: begin
          if (haveLatchedLen) begin
            startAddr      <= addrReg;
            strideInterval <= strideReg;
            startLatency   <= startLatReg;
            endLatency     <= endLatReg;
            valid          <= 1'b1;
            writeEn        <= 1'b1;
            stateReg       <= SETUP;
          end
        end
        SETUP: begin
          if (!opReg) begin
            if (popEn) begin
              dataIn    <= mem[rdPtrReg];
              remainReg <= lenReg - 1'b1;
              stateReg  <= STREAM;
            end else begin
              writeEn  <= 1'b0;
              done     <= 1'b1;
              stateReg <= IDLE;
            end
          end else if (endLatency == '0) begin
            done     <= 1'b1;
            stateReg <= IDLE;
          end else begin
            latCntReg <= endLatency - 1'b1;
            stateReg  <= RUN_WAIT;
          end
        end
        STREAM: begin
          if (popEn) begin
            dataIn    <= mem[rdPtrReg];
            remainReg <= remainReg - 1'b1;
          end else begin
            dataIn   <= '0;
            writeEn  <= 1'b0;
            done     <= 1'b1;
            stateReg <= IDLE;
          end
        end
        RUN_WAIT: begin
          if (latCntReg == '0) begin
            done     <= 1'b1;
            stateReg <= IDLE;
          end else begin
            latCntReg <= latCntReg - 1'b1;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_cfg_sequencer.sv
// Directed bench for conv_cfg_sequencer: LOAD/RUN timing, FIFO full handling, async reset abort.
// The command-check section depends on CFG_SEQ_CMD_CHECK_EN.
module tb_conv_cfg_sequencer;

  logic          clk;
  logic          rst;
  logic [42:0]   cfg_wdata;
  logic          cfg_wvalid;
  logic          cfg_wready;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [4:0]    cmd_addr;
  logic [3:0]    cmd_stride;
  logic [4:0]    cmd_len;
  logic [15:0]   cmd_start_lat;
  logic [15:0]   cmd_end_lat;
  logic [125:0]  cmd_gctl;
  logic          cmd_mux_sel;
  logic [42:0]   dataIn;
  logic [4:0]    startAddr;
  logic [3:0]    strideInterval;
  logic [15:0]   startLatency;
  logic [15:0]   endLatency;
  logic          valid;
  logic          writeEn;
  logic [125:0]  gControlIn;
  logic          mux_sel;
  logic          done;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;
  logic [125:0] gPat;

  conv_cfg_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_wdata(cfg_wdata), .cfg_wvalid(cfg_wvalid), .cfg_wready(cfg_wready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
    .cmd_start_lat(cmd_start_lat), .cmd_end_lat(cmd_end_lat),
    .cmd_gctl(cmd_gctl), .cmd_mux_sel(cmd_mux_sel),
    .dataIn(dataIn), .startAddr(startAddr), .strideInterval(strideInterval),
    .startLatency(startLatency), .endLatency(endLatency),
    .valid(valid), .writeEn(writeEn), .gControlIn(gControlIn), .mux_sel(mux_sel),
    .done(done), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [42:0] wordOf(input int i);
    return 43'h00D30900000 + 43'(i) * 43'h10001;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input logic [42:0] w);
    cfg_wdata  = w;
    cfg_wvalid = 1'b1;
    tick();
    cfg_wvalid = 1'b0;
  endtask

  // Waits (bounded) for cmd_ready, then presents the command for exactly one cycle.
  task automatic sendCmd(input logic op, input logic [4:0] addr, input logic [3:0] stride,
                         input logic [4:0] len, input logic [15:0] slat, input logic [15:0] elat,
                         input logic [125:0] gctl, input logic mux);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_op = op; cmd_addr = addr; cmd_stride = stride; cmd_len = len;
    cmd_start_lat = slat; cmd_end_lat = elat; cmd_gctl = gctl; cmd_mux_sel = mux;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic sawDone;
    logic [42:0] e;
    gPat = {6'h2D, 120'hDEADBEEF_CAFEF00D_0123_4567_89AB_D8};
    rst = 1'b0; cfg_wdata = '0; cfg_wvalid = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
    cmd_addr = '0; cmd_stride = '0; cmd_len = '0; cmd_start_lat = '0; cmd_end_lat = '0;
    cmd_gctl = '0; cmd_mux_sel = 1'b0;

    // Reset state
    #2;
    chk("rst_cfg_wready", cfg_wready, 1);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_done", done, 0);
    chk("rst_dataIn", dataIn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_gctl", gControlIn, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // LOAD len=5 with all words already buffered
    for (int i = 0; i < 5; i++) pushWord(wordOf(i));
    sendCmd(1'b0, 5'd0, 4'd1, 5'd5, 16'd0, 16'd9, '0, 1'b0);
    chk("t1_valid", valid, 1);
    chk("t1_writeEn", writeEn, 1);
    chk("t1_startAddr", startAddr, 0);
    chk("t1_endLat", endLatency, 9);
    chk("t1_stride", strideInterval, 1);
    chk("t1_busy", busy, 1);
    chk("t1_cmd_ready", cmd_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t1_dataIn", dataIn, wordOf(k));
      chk("t1_we_stream", writeEn, 1);
      chk("t1_valid_low", valid, 0);
    end
    tick();
    chk("t1_done", done, 1);
    chk("t1_dataIn_zero", dataIn, 0);
    chk("t1_we_end", writeEn, 0);
    chk("t1_ready_in_done", cmd_ready, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_ready_after", cmd_ready, 1);

    // LOAD len=4 with only 2 buffered; valid waits for the 4th word
    pushWord(wordOf(5));
    pushWord(wordOf(6));
    sendCmd(1'b0, 5'd3, 4'd2, 5'd4, 16'd0, 16'd0, '0, 1'b0);
    chk("t2_fill_valid", valid, 0);
    chk("t2_fill_busy", busy, 1);
    tick(); tick();
    pushWord(wordOf(7));
    chk("t2_valid_3w", valid, 0);
    pushWord(wordOf(8));
    chk("t2_valid_4w", valid, 0);
    tick();
    chk("t2_valid", valid, 1);
    chk("t2_startAddr", startAddr, 3);
    chk("t2_writeEn", writeEn, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_dataIn", dataIn, wordOf(5 + k));
    end
    tick();
    chk("t2_done", done, 1);

    // RUN: valid at A+1, done at V+21, gate control held
    sendCmd(1'b1, 5'd5, 4'd0, 5'd0, 16'd15, 16'd20, gPat, 1'b1);
    chk("t3_valid", valid, 1);
    chk("t3_writeEn", writeEn, 0);
    chk("t3_startAddr", startAddr, 5);
    chk("t3_startLat", startLatency, 15);
    chk("t3_gctl", gControlIn, gPat);
    chk("t3_mux", mux_sel, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < 40);
    chk("t3_done_offset", n, 21);
    tick();
    chk("t3_gctl_held", gControlIn, gPat);
    chk("t3_mux_held", mux_sel, 1);
    chk("t3_dataIn", dataIn, 0);

    // FIFO full: 17th push refused; push with concurrent pop keeps count
    for (int k = 0; k < 16; k++) pushWord(wordOf(20 + k));
    chk("t4_full_wready", cfg_wready, 0);
    pushWord(wordOf(36));
    chk("t4_still_full", cfg_wready, 0);
    sendCmd(1'b0, 5'd0, 4'd0, 5'd2, 16'd0, 16'd0, '0, 1'b0);
    chk("t4_valid", valid, 1);
    tick();
    chk("t4_d0", dataIn, wordOf(20));
    chk("t4_wready_15", cfg_wready, 1);
    pushWord(wordOf(40));
    chk("t4_d1", dataIn, wordOf(21));
    chk("t4_wready_pushpop", cfg_wready, 1);
    tick();
    chk("t4_done", done, 1);
    pushWord(wordOf(41));
    chk("t4_full_again", cfg_wready, 0);
    sendCmd(1'b0, 5'd0, 4'd0, 5'd16, 16'd0, 16'd0, '0, 1'b0);
    chk("t4_valid16", valid, 1);
    for (int k = 0; k < 16; k++) begin
      tick();
      e = (k < 14) ? wordOf(22 + k) : ((k == 14) ? wordOf(40) : wordOf(41));
      chk("t4_drain", dataIn, e);
    end
    tick();
    chk("t4_done16", done, 1);
    chk("t4_empty_wready", cfg_wready, 1);

    // Async reset mid-STREAM
    for (int k = 0; k < 4; k++) pushWord(wordOf(50 + k));
    sendCmd(1'b0, 5'd7, 4'd3, 5'd4, 16'd1, 16'd2, '0, 1'b0);
    tick(); tick();
    chk("t5_mid_data", dataIn, wordOf(51));
    rst = 1'b0;
    #1;
    chk("t5_rst_dataIn", dataIn, 0);
    chk("t5_rst_we", writeEn, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_wready", cfg_wready, 1);
    chk("t5_rst_addr", startAddr, 0);
    chk("t5_rst_gctl", gControlIn, 0);
    tick(); tick();
    rst = 1'b1;
    sawDone = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done === 1'b1) sawDone = 1'b1;
    end
    chk("t5_no_done", sawDone, 0);
    sendCmd(1'b0, 5'd0, 4'd0, 5'd1, 16'd0, 16'd0, '0, 1'b0);
    chk("t5_fill_after_rst", valid, 0);
    chk("t5_fill_busy", busy, 1);
    pushWord(wordOf(60));
    tick();
    chk("t5_valid", valid, 1);
    tick();
    chk("t5_data", dataIn, wordOf(60));
    tick();
    chk("t5_done", done, 1);

`ifdef CFG_SEQ_CMD_CHECK_EN
    // Rejected LOAD len=17
    sendCmd(1'b0, 5'd0, 4'd0, 5'd17, 16'd0, 16'd0, '0, 1'b0);
    chk("t6_err", err, 1);
    chk("t6_valid", valid, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_busy", busy, 0);
    tick();
    chk("t6_no_done", done, 0);
    chk("t6_err_sticky", err, 1);
`else
    tick();
    chk("t6_err_tied", err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
